// File: rtl/mod_exp_pkg.sv
// ============================================================================
// Module : mod_exp_pkg
// Brief  : Shared types, defaults and helpers for the modular-exponentiation
//          controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_exp_pkg;

  localparam int DEF_DATA_WIDTH = 255;
  localparam int DEF_EXP_WIDTH  = 255;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_ONE_MONT =
    255'hc1258acd66282b7ccc627f7f65e27faac425bfd0001a40100000000ffffffff;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SQ_REQ    = 3'd1,
    ST_SQ_WAIT   = 3'd2,
    ST_MUL_REQ   = 3'd3,
    ST_MUL_WAIT  = 3'd4,
    ST_CONV_REQ  = 3'd5,
    ST_CONV_WAIT = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  // Counter must hold the full exponent width, not just width-1.
  function automatic int cnt_width(input int exp_width);
    return $clog2(exp_width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_exp_ctrl_if.sv
// ============================================================================
// Module : mod_exp_ctrl_if
// Brief  : Command, result and multiplier handshake bundle of mod_exp_ctrl.
//          slave = controller view, master = surrounding system view.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod_exp_ctrl_if
  import mod_exp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH
);

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [DATA_WIDTH-1:0] base_i;
  logic [EXP_WIDTH-1:0]  exp_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [DATA_WIDTH-1:0] res_o;
  logic                  mm_op_valid_o;
  logic                  mm_op_ready_i;
  logic [DATA_WIDTH-1:0] mm_op1_o;
  logic [DATA_WIDTH-1:0] mm_op2_o;
  logic                  mm_res_valid_i;
  logic                  mm_res_ready_o;
  logic [DATA_WIDTH-1:0] mm_res_i;

  modport slave (
    input  cmd_valid_i, base_i, exp_i, res_ready_i,
           mm_op_ready_i, mm_res_valid_i, mm_res_i,
    output cmd_ready_o, res_valid_o, res_o,
           mm_op_valid_o, mm_op1_o, mm_op2_o, mm_res_ready_o
  );

  modport master (
    output cmd_valid_i, base_i, exp_i, res_ready_i,
           mm_op_ready_i, mm_res_valid_i, mm_res_i,
    input  cmd_ready_o, res_valid_o, res_o,
           mm_op_valid_o, mm_op1_o, mm_op2_o, mm_res_ready_o
  );

endinterface

`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
// ============================================================================
// Module : mod_exp_ctrl
// Brief  : Left-to-right square-and-multiply controller driving an external
//          Montgomery multiplier, one operation in flight at a time.
//          Define MOD_EXP_FROM_MONT_EN to convert the result out of the
//          Montgomery domain with one extra multiply by 1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    EXP_WIDTH  = DEF_EXP_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ONE_MONT   = DATA_WIDTH'(DEF_ONE_MONT)
)(
  input wire            clk,
  input wire            rst_n,
  mod_exp_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(EXP_WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(EXP_WIDTH);
`ifdef MOD_EXP_FROM_MONT_EN
  localparam logic [DATA_WIDTH-1:0] c_one = DATA_WIDTH'(1);
`endif

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_base;
  logic [EXP_WIDTH-1:0]  r_exp;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cmd_ready;
  logic                  r_op_valid;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic                  r_res_ready;
  logic                  r_res_valid;

  logic w_last;
  logic w_mul;

  assign w_last = (r_cnt == CNT_W'(1));
  assign w_mul  = (r_state == ST_SQ_WAIT) && r_exp[EXP_WIDTH-1];

  // Operands are loaded on the transition into a request state, so they are
  // taken straight from the incoming result rather than from r_acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_op_valid  <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_res_ready <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid_i) begin
            r_base      <= bus.base_i;
            r_exp       <= bus.exp_i;
            r_acc       <= ONE_MONT;
            r_cnt       <= c_cnt_init;
            r_cmd_ready <= 1'b0;
            r_op_valid  <= 1'b1;
            r_op1       <= ONE_MONT;
            r_op2       <= ONE_MONT;
            r_state     <= ST_SQ_REQ;
          end
        end
        ST_SQ_REQ, ST_MUL_REQ: begin
          if (bus.mm_op_ready_i) begin
            r_op_valid  <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_res_ready <= 1'b1;
            r_state     <= (r_state == ST_SQ_REQ) ? ST_SQ_WAIT : ST_MUL_WAIT;
          end
        end
        ST_SQ_WAIT, ST_MUL_WAIT: begin
          if (bus.mm_res_valid_i) begin
            r_acc       <= bus.mm_res_i;
            r_res_ready <= 1'b0;
            if (w_mul) begin
              r_op_valid <= 1'b1;
              r_op1      <= bus.mm_res_i;
              r_op2      <= r_base;
              r_state    <= ST_MUL_REQ;
            end else begin
              r_exp <= r_exp << 1;
              r_cnt <= r_cnt - 1'b1;
              if (!w_last) begin
                r_op_valid <= 1'b1;
                r_op1      <= bus.mm_res_i;
                r_op2      <= bus.mm_res_i;
                r_state    <= ST_SQ_REQ;
              end else begin
`ifdef MOD_EXP_FROM_MONT_EN
                r_op_valid <= 1'b1;
                r_op1      <= bus.mm_res_i;
                r_op2      <= c_one;
                r_state    <= ST_CONV_REQ;
`else
                r_res_valid <= 1'b1;
                r_state     <= ST_DONE;
`endif
              end
            end
          end
        end
`ifdef MOD_EXP_FROM_MONT_EN
        ST_CONV_REQ: begin
          if (bus.mm_op_ready_i) begin
            r_op_valid  <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_res_ready <= 1'b1;
            r_state     <= ST_CONV_WAIT;
          end
        end
        ST_CONV_WAIT: begin
          if (bus.mm_res_valid_i) begin
            r_acc       <= bus.mm_res_i;
            r_res_ready <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (bus.res_ready_i) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_op_valid  <= 1'b0;
          r_op1       <= '0;
          r_op2       <= '0;
          r_res_ready <= 1'b0;
          r_res_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o    = r_cmd_ready;
  assign bus.mm_op_valid_o  = r_op_valid;
  assign bus.mm_op1_o       = r_op1;
  assign bus.mm_op2_o       = r_op2;
  assign bus.mm_res_ready_o = r_res_ready;
  assign bus.res_valid_o    = r_res_valid;
  assign bus.res_o          = r_res_valid ? r_acc : '0;

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
// ============================================================================
// Module : tb_mod_exp_ctrl
// Brief  : Directed bench for mod_exp_ctrl (8-bit, modulus 251, R = 256) with
//          a behavioural Montgomery multiplier of random latency.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mod_exp_ctrl;
  import mod_exp_pkg::*;

  localparam int DW = 8;
  localparam int EW = 4;

`ifdef MOD_EXP_FROM_MONT_EN
  localparam logic [7:0] R_1010 = 8'd20;
  localparam logic [7:0] R_0000 = 8'd1;
  localparam logic [7:0] R_1111 = 8'd138;
  localparam int         N_CONV = 1;
`else
  localparam logic [7:0] R_1010 = 8'd100;
  localparam logic [7:0] R_0000 = 8'd5;
  localparam logic [7:0] R_1111 = 8'd188;
  localparam int         N_CONV = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mod_exp_ctrl_if #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) bus ();

  mod_exp_ctrl #(.DATA_WIDTH(DW), .EXP_WIDTH(EW), .ONE_MONT(8'd5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec     = 0;
  int n_err     = 0;
  int n_ops     = 0;
  int max_stall = 0;

  // a * b * R^-1 mod 251, with R^-1 = 201 (256 * 201 = 1 mod 251)
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = (int'(a) * int'(b)) % 251;
    p = (p * 201) % 251;
    return 8'(p);
  endfunction

  // Behavioural multiplier: all decisions on the falling edge, using values
  // recorded at the previous falling edge to see what the rising edge did.
  bit         m_busy;
  logic [7:0] m_res;
  bit         p_vld, p_rdy, p_rres;
  logic [7:0] p_a, p_b;
  int         m_wait, m_lat;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mm_op_ready_i  = 1'b0;
      bus.mm_res_valid_i = 1'b0;
      bus.mm_res_i       = '0;
      m_busy = 0; p_vld = 0; p_rdy = 0; p_rres = 0;
      p_a = '0; p_b = '0; m_wait = 0; m_lat = 0;
    end else begin
      if (bus.mm_res_valid_i && p_rres) begin
        bus.mm_res_valid_i = 1'b0;
        bus.mm_res_i       = '0;
        m_busy             = 0;
      end
      if (p_vld && p_rdy) begin
        n_vec++;
        if (m_busy) begin
          n_err++;
          $display("FAIL in_flight: request accepted while busy=%0d, required busy=0", m_busy);
        end
        m_busy = 1;
        m_res  = mont(p_a, p_b);
        n_ops++;
        m_lat  = $urandom_range(0, max_stall);
        m_wait = $urandom_range(0, max_stall);
      end else if (p_vld) begin
        n_vec++;
        if (bus.mm_op_valid_o !== 1'b1 || bus.mm_op1_o !== p_a || bus.mm_op2_o !== p_b) begin
          n_err++;
          $display("FAIL op_stable: valid=%b op1=%0d op2=%0d, required 1 %0d %0d",
                   bus.mm_op_valid_o, bus.mm_op1_o, bus.mm_op2_o, p_a, p_b);
        end
      end
      if (m_busy) begin
        n_vec++;
        if (bus.mm_op_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL overlap: mm_op_valid_o=%b while busy, required 0", bus.mm_op_valid_o);
        end
      end
      bus.mm_op_ready_i = 1'b0;
      if (!m_busy && bus.mm_op_valid_o === 1'b1) begin
        if (m_wait == 0) bus.mm_op_ready_i = 1'b1;
        else m_wait--;
      end
      if (m_busy && !bus.mm_res_valid_i) begin
        if (m_lat == 0) begin
          bus.mm_res_valid_i = 1'b1;
          bus.mm_res_i       = m_res;
        end else m_lat--;
      end
      p_vld  = (bus.mm_op_valid_o === 1'b1);
      p_a    = bus.mm_op1_o;
      p_b    = bus.mm_op2_o;
      p_rdy  = bus.mm_op_ready_i;
      p_rres = (bus.mm_res_ready_o === 1'b1);
    end
  end

  task automatic send_cmd(input logic [7:0] b, input logic [3:0] e);
    int t = 0;
    @(negedge clk);
    while (bus.cmd_ready_o !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (bus.cmd_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_timeout: cmd_ready_o=%b, required 1", bus.cmd_ready_o);
    end
    n_ops           = 0;
    bus.cmd_valid_i = 1'b1;
    bus.base_i      = b;
    bus.exp_i       = e;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.base_i      = '0;
    bus.exp_i       = '0;
  endtask

  task automatic get_result(input string name, input logic [7:0] er, input int eops);
    int t = 0;
    while (bus.res_valid_o !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (bus.res_valid_o !== 1'b1 || bus.res_o !== er) begin
      n_err++;
      $display("FAIL %s_res: valid=%b res_o=%0d, required 1 %0d", name, bus.res_valid_o, bus.res_o, er);
    end
    n_vec++;
    if (n_ops !== eops) begin
      n_err++;
      $display("FAIL %s_ops: %0d multiplier ops, required %0d", name, n_ops, eops);
    end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    n_vec++;
    if (bus.res_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_hs: res_valid_o=%b cmd_ready_o=%b, required 0 1",
               name, bus.res_valid_o, bus.cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: %b, required 1", bus.cmd_ready_o); end
    n_vec++;
    if (bus.res_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: %b, required 0", bus.res_valid_o); end
    n_vec++;
    if (bus.res_o !== 8'd0) begin n_err++; $display("FAIL rst_res: %0d, required 0", bus.res_o); end
    n_vec++;
    if (bus.mm_op_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_op_valid: %b, required 0", bus.mm_op_valid_o); end
    n_vec++;
    if (bus.mm_op1_o !== 8'd0 || bus.mm_op2_o !== 8'd0) begin
      n_err++; $display("FAIL rst_ops: op1=%0d op2=%0d, required 0 0", bus.mm_op1_o, bus.mm_op2_o);
    end
    n_vec++;
    if (bus.mm_res_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_res_ready: %b, required 0", bus.mm_res_ready_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_square_multiply();
    max_stall = 0;
    send_cmd(8'd10, 4'b1010);
    get_result("exp1010", R_1010, 6 + N_CONV);
  endtask

  task automatic test_exp_zero();
    send_cmd(8'd10, 4'b0000);
    get_result("exp0000", R_0000, 4 + N_CONV);
  endtask

  task automatic test_exp_ones();
    send_cmd(8'd10, 4'b1111);
    get_result("exp1111", R_1111, 8 + N_CONV);
  endtask

  task automatic test_stalls();
    max_stall = 5;
    for (int i = 0; i < 3; i++) begin
      send_cmd(8'd10, 4'b1010);
      get_result("stall1010", R_1010, 6 + N_CONV);
      send_cmd(8'd10, 4'b1111);
      get_result("stall1111", R_1111, 8 + N_CONV);
    end
  endtask

  task automatic test_res_backpressure();
    int t = 0;
    max_stall = 2;
    send_cmd(8'd10, 4'b1010);
    while (bus.res_valid_o !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    bus.cmd_valid_i = 1'b1;
    bus.base_i      = 8'd10;
    bus.exp_i       = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (bus.res_valid_o !== 1'b1 || bus.res_o !== R_1010 || bus.cmd_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: valid=%b res_o=%0d cmd_ready=%b, required 1 %0d 0",
                 bus.res_valid_o, bus.res_o, bus.cmd_ready_o, R_1010);
      end
      @(negedge clk);
    end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    n_ops = 0;
    n_vec++;
    if (bus.res_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: res_valid_o=%b cmd_ready_o=%b, required 0 1", bus.res_valid_o, bus.cmd_ready_o);
    end
    @(negedge clk);
    n_vec++;
    if (bus.cmd_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept: cmd_ready_o=%b, required 0", bus.cmd_ready_o);
    end
    bus.cmd_valid_i = 1'b0;
    bus.base_i      = '0;
    bus.exp_i       = '0;
    get_result("bp_next", R_1111, 8 + N_CONV);
  endtask

  task automatic test_async_reset();
    int t = 0;
    max_stall = 3;
    send_cmd(8'd10, 4'b1111);
    while (dut.r_state != ST_MUL_WAIT && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (dut.r_state != ST_MUL_WAIT) begin
      n_err++;
      $display("FAIL ar_reach: state=%0d, required %0d", dut.r_state, ST_MUL_WAIT);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.cmd_ready_o !== 1'b1 || bus.mm_op_valid_o !== 1'b0 || bus.mm_res_ready_o !== 1'b0 ||
        bus.res_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL ar_outputs: cmd_rdy=%b op_vld=%b res_rdy=%b res_vld=%b, required 1 0 0 0",
               bus.cmd_ready_o, bus.mm_op_valid_o, bus.mm_res_ready_o, bus.res_valid_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_cmd(8'd10, 4'b1010);
    get_result("ar_after", R_1010, 6 + N_CONV);
  endtask

  task automatic test_back_to_back();
    max_stall = 1;
    send_cmd(8'd10, 4'b0000);
    get_result("b2b_first", R_0000, 4 + N_CONV);
    send_cmd(8'd10, 4'b1010);
    get_result("b2b_second", R_1010, 6 + N_CONV);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.base_i      = '0;
    bus.exp_i       = '0;
    bus.res_ready_i = 1'b0;
    test_reset();
    test_square_multiply();
    test_exp_zero();
    test_exp_ones();
    test_stalls();
    test_res_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
